dmem_responder: RTL and testbench

Data-memory responder serving the MIPS pipeline's memory-stage port: address `aluoutM`, store data `writedataM`, load data `readdataM`. It accepts one load or store at a time, holds the pipeline with `stall` for a fixed wait latency, then commits the store or returns the loaded word. It sits between the datapath's M stage and on-chip RAM, and is the responder half of the memory interface the datapath initiates.

---
 rtl/dmem_responder.sv | 140 ++++++++++++++
 tb/tb_dmem_responder.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the M stage: one load/store at a time, stall held LATENCY cycles, then a 1-cycle resp_valid.
// Latency LATENCY+1 per access; backpressure is the combinational stall. Optional misalignment errors under DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        cap_we;
    logic [1:0]  cap_size;
    logic [31:0] cap_addr, cap_wdata;

    logic        acc_we;
    logic [1:0]  acc_size;
    logic [31:0] acc_addr, acc_wdata;
    logic [DEPTH_LOG2-1:0] idx;
    logic        commit;
    logic        range_err, align_err, access_err;
    logic [3:0]  be;
    logic [31:0] lane_dat;

    logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        stall      = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    stall     = 1'b1;
                    cnt_nxt   = 4'(LATENCY - 1);
                    state_nxt = (LATENCY == 1) ? DONE : BUSY;
                end
            end
            BUSY: begin
                stall   = 1'b1;
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1)
                    state_nxt = DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // With LATENCY==1 the access happens on the capture edge, so use live inputs while in IDLE.
    always_comb begin
        acc_we    = (state == IDLE) ? req_we    : cap_we;
        acc_size  = (state == IDLE) ? req_size  : cap_size;
        acc_addr  = (state == IDLE) ? req_addr  : cap_addr;
        acc_wdata = (state == IDLE) ? req_wdata : cap_wdata;
    end

    assign commit    = (state != DONE) && (state_nxt == DONE);
    assign idx       = acc_addr[DEPTH_LOG2+1:2];
    assign range_err = |(acc_addr >> (DEPTH_LOG2 + 2));

`ifdef DMEM_ALIGN_CHECK_EN
    assign align_err = ((acc_size == 2'd1) && acc_addr[0]) ||
                       (acc_size[1] && (acc_addr[1:0] != 2'b00));
`else
    assign align_err = 1'b0;
`endif

    assign access_err = range_err | align_err;

    always_comb begin
        be       = 4'hF;
        lane_dat = acc_wdata;
        case (acc_size)
            2'd0: begin
                be       = 4'b0001 << acc_addr[1:0];
                lane_dat = {4{acc_wdata[7:0]}};
            end
            2'd1: begin
                be       = acc_addr[1] ? 4'b1100 : 4'b0011;
                lane_dat = {2{acc_wdata[15:0]}};
            end
            default: begin
                be       = 4'hF;
                lane_dat = acc_wdata;
            end
        endcase
    end

    // Reset wins over a commit on the same edge, so an in-flight store is dropped.
    always_ff @(posedge clk) begin
        if (!rst && commit && acc_we && !access_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i])
                    mem[idx][i*8 +: 8] <= lane_dat[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            cap_we     <= 1'b0;
            cap_size   <= 2'd0;
            cap_addr   <= 32'd0;
            cap_wdata  <= 32'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && req_valid) begin
                cap_we    <= req_we;
                cap_size  <= req_size;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
            end
            if (commit) begin
                resp_err   <= access_err;
                resp_rdata <= access_err ? 32'd0 : mem[idx];
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance for data paths and a LATENCY=1 instance for hold behaviour.
module tb_dmem_responder;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        stall, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    logic        req1_valid, req1_we;
    logic [1:0]  req1_size;
    logic [31:0] req1_addr, req1_wdata;
    logic        stall1, resp_valid1, resp_err1;
    logic [31:0] resp_rdata1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_LOG2(10), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req1_valid), .req_we(req1_we), .req_size(req1_size),
        .req_addr(req1_addr), .req_wdata(req1_wdata),
        .stall(stall1), .resp_valid(resp_valid1),
        .resp_rdata(resp_rdata1), .resp_err(resp_err1)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Called at posedge+1 of the request's first cycle; returns at posedge+1 after the DONE cycle.
    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input bit chk_rd, input logic [31:0] exp_rd, input logic exp_err);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        for (int c = 0; c < LAT; c++) begin
            @(negedge clk);
            check({tag, "/stall"}, 32'(stall), 32'd1);
            check({tag, "/rv_early"}, 32'(resp_valid), 32'd0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        @(negedge clk);
        check({tag, "/rv"}, 32'(resp_valid), 32'd1);
        check({tag, "/stall_done"}, 32'(stall), 32'd0);
        check({tag, "/err"}, 32'(resp_err), 32'(exp_err));
        if (chk_rd)
            check({tag, "/rdata"}, resp_rdata, exp_rd);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_addr = 32'd0; req_wdata = 32'd0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_size = 2'd0; req1_addr = 32'd0; req1_wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst0/stall", 32'(stall), 32'd0);
        check("rst0/rv", 32'(resp_valid), 32'd0);
        check("rst0/rdata", resp_rdata, 32'd0);
        check("rst0/err", 32'(resp_err), 32'd0);
        check("rst0/stall1", 32'(stall1), 32'd0);
        @(posedge clk); #1;

        do_req("init40", 1'b1, 2'd2, 32'h40, 32'h0000_0000, 1'b0, 32'd0, 1'b0);
        do_req("init10", 1'b1, 2'd2, 32'h10, 32'h1111_1111, 1'b0, 32'd0, 1'b0);
        do_req("init00", 1'b1, 2'd2, 32'h00, 32'h5A5A_5A5A, 1'b0, 32'd0, 1'b0);

        do_req("st_word", 1'b1, 2'd2, 32'h40, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000, 1'b0);
        do_req("ld_word", 1'b0, 2'd2, 32'h40, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);

        do_req("clr40", 1'b1, 2'd2, 32'h40, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF, 1'b0);
        do_req("st_byte", 1'b1, 2'd0, 32'h42, 32'hFFFF_FFAB, 1'b1, 32'h0000_0000, 1'b0);
        do_req("st_half", 1'b1, 2'd1, 32'h40, 32'hCDEF_1234, 1'b1, 32'h00AB_0000, 1'b0);
        do_req("ld_lanes", 1'b0, 2'd2, 32'h40, 32'h0, 1'b1, 32'h00AB_1234, 1'b0);

        do_req("st_oor", 1'b1, 2'd2, 32'h0000_1000, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b1);
        do_req("ld_00", 1'b0, 2'd2, 32'h00, 32'h0, 1'b1, 32'h5A5A_5A5A, 1'b0);
        do_req("ld_oor", 1'b0, 2'd3, 32'h8000_0000, 32'h0, 1'b1, 32'h0, 1'b1);

`ifdef DMEM_ALIGN_CHECK_EN
        do_req("st_mis", 1'b1, 2'd2, 32'h41, 32'hCAFE_F00D, 1'b1, 32'h0, 1'b1);
        do_req("ld_mis", 1'b0, 2'd2, 32'h40, 32'h0, 1'b1, 32'h00AB_1234, 1'b0);
`else
        do_req("st_mis", 1'b1, 2'd2, 32'h41, 32'hCAFE_F00D, 1'b1, 32'h00AB_1234, 1'b0);
        do_req("ld_mis", 1'b0, 2'd2, 32'h40, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0);
`endif

        // Reset in the middle of a store to 0x10; the store must be dropped.
        do_req("ld_10a", 1'b0, 2'd2, 32'h10, 32'h0, 1'b1, 32'h1111_1111, 1'b0);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h10; req_wdata = 32'h2222_2222;
        @(negedge clk);
        check("rstbusy/stall_c0", 32'(stall), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("rstbusy/stall_c1", 32'(stall), 32'd1);
        rst = 1'b1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstbusy/stall", 32'(stall), 32'd0);
        check("rstbusy/rv", 32'(resp_valid), 32'd0);
        check("rstbusy/rdata", resp_rdata, 32'd0);
        check("rstbusy/err", 32'(resp_err), 32'd0);
        @(posedge clk); #1;
        do_req("ld_10b", 1'b0, 2'd2, 32'h10, 32'h0, 1'b1, 32'h1111_1111, 1'b0);

        // Request held continuously on the LATENCY=1 instance.
        req1_valid = 1'b1; req1_we = 1'b0; req1_size = 2'd2; req1_addr = 32'h0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("hold/stall%0d", i), 32'(stall1), (i % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("hold/rv%0d", i), 32'(resp_valid1), (i % 2 == 1) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
        end
        req1_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
